// File: rtl/sobel_mac_sched.sv
// sobel_mac_sched: sequences one SB_MAC16 tile to compute the Sobel Gx and Gy
// of a latched 3x3 window with twelve multiply-accumulate steps, then presents
// gx, gy and the saturated magnitude |gx|+|gy| on a valid/ready output.
// Optional build macro SOBEL_THRESH_EN adds thresh_i / edge_o (mag > thresh_i).
module sobel_mac_sched #(
  parameter int PIX_W = 8,
  parameter int MAG_W = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               win_valid_i,
  output logic               win_ready_o,
  input  logic [9*PIX_W-1:0] win_i,
  output logic               mac_ce_o,
  output logic [15:0]        mac_a_o,
  output logic [15:0]        mac_b_o,
  output logic               mac_addsub_o,
  output logic               mac_oload_o,
  input  logic [31:0]        mac_o_i,
`ifdef SOBEL_THRESH_EN
  input  logic [MAG_W-1:0]   thresh_i,
  output logic               edge_o,
`endif
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [10:0]        gx_o,
  output logic [10:0]        gy_o,
  output logic [MAG_W-1:0]   mag_o
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_GX   = 3'd1;
  localparam logic [2:0] ST_GY   = 3'd2;
  localparam logic [2:0] ST_CAP  = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  localparam logic [31:0] LP_MAG_MAX = (32'd1 << MAG_W) - 32'd1;

  logic [2:0]         r_state;
  logic [2:0]         r_tap;
  logic [9*PIX_W-1:0] r_win;
  logic [10:0]        r_gx;
  logic [10:0]        r_gy;
  logic [MAG_W-1:0]   r_mag;
`ifdef SOBEL_THRESH_EN
  logic               r_edge;
`endif

  logic [PIX_W-1:0]   w_p [9];
  logic [3:0]         w_pix_idx;
  logic [1:0]         w_coef;
  logic               w_sub;
  logic [PIX_W-1:0]   w_pix;
  logic               w_active;
  logic               w_last_tap;
  logic [10:0]        w_gy_cap;
  logic [10:0]        w_gx_abs;
  logic [10:0]        w_gy_abs;
  logic [11:0]        w_sum;
  logic [31:0]        w_sum_ext;
  logic [MAG_W-1:0]   w_mag_sat;
  logic               w_unused_mac_hi;

  // Unpack the latched window into pixels p0..p8 (row-major, p0 top-left).
  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      w_p[k] = r_win[k*PIX_W +: PIX_W];
    end
  end

  // Tap table: pixel index, |coefficient| and sign for the current pass/tap.
  always_comb begin
    w_pix_idx = 4'd0;
    w_coef    = 2'd0;
    w_sub     = 1'b0;
    case (r_state)
      ST_GX: begin
        case (r_tap)
          3'd0:    begin w_pix_idx = 4'd0; w_coef = 2'd1; w_sub = 1'b1; end
          3'd1:    begin w_pix_idx = 4'd2; w_coef = 2'd1; w_sub = 1'b0; end
          3'd2:    begin w_pix_idx = 4'd3; w_coef = 2'd2; w_sub = 1'b1; end
          3'd3:    begin w_pix_idx = 4'd5; w_coef = 2'd2; w_sub = 1'b0; end
          3'd4:    begin w_pix_idx = 4'd6; w_coef = 2'd1; w_sub = 1'b1; end
          3'd5:    begin w_pix_idx = 4'd8; w_coef = 2'd1; w_sub = 1'b0; end
          default: begin w_pix_idx = 4'd0; w_coef = 2'd0; w_sub = 1'b0; end
        endcase
      end
      ST_GY: begin
        case (r_tap)
          3'd0:    begin w_pix_idx = 4'd0; w_coef = 2'd1; w_sub = 1'b1; end
          3'd1:    begin w_pix_idx = 4'd1; w_coef = 2'd2; w_sub = 1'b1; end
          3'd2:    begin w_pix_idx = 4'd2; w_coef = 2'd1; w_sub = 1'b1; end
          3'd3:    begin w_pix_idx = 4'd6; w_coef = 2'd1; w_sub = 1'b0; end
          3'd4:    begin w_pix_idx = 4'd7; w_coef = 2'd2; w_sub = 1'b0; end
          3'd5:    begin w_pix_idx = 4'd8; w_coef = 2'd1; w_sub = 1'b0; end
          default: begin w_pix_idx = 4'd0; w_coef = 2'd0; w_sub = 1'b0; end
        endcase
      end
      default: begin
        w_pix_idx = 4'd0;
        w_coef    = 2'd0;
        w_sub     = 1'b0;
      end
    endcase
  end

  assign w_pix      = w_p[w_pix_idx];
  assign w_active   = (r_state == ST_GX) || (r_state == ST_GY);
  assign w_last_tap = (r_tap == 3'd5);

  // MAC pins are quiet (all zero) outside the two accumulate passes.
  assign mac_ce_o     = w_active;
  assign mac_oload_o  = w_active && (r_tap == 3'd0);
  assign mac_addsub_o = w_active && w_sub;
  assign mac_a_o      = w_active ? {{(16-PIX_W){1'b0}}, w_pix} : '0;
  assign mac_b_o      = w_active ? {14'd0, w_coef} : '0;

  // Gradients fit in 11 signed bits; the accumulator's upper bits are sign copies.
  assign w_unused_mac_hi = ^mac_o_i[31:11];
  assign w_gy_cap        = mac_o_i[10:0];
  assign w_gx_abs        = r_gx[10] ? (11'd0 - r_gx) : r_gx;
  assign w_gy_abs        = w_gy_cap[10] ? (11'd0 - w_gy_cap) : w_gy_cap;
  assign w_sum           = {1'b0, w_gx_abs} + {1'b0, w_gy_abs};
  assign w_sum_ext       = {20'd0, w_sum};
  assign w_mag_sat       = (w_sum_ext > LP_MAG_MAX) ? LP_MAG_MAX[MAG_W-1:0]
                                                    : w_sum_ext[MAG_W-1:0];

  // Ready is gated by reset so no window is taken while rstn_i is low.
  assign win_ready_o = rstn_i && (r_state == ST_IDLE);
  assign res_valid_o = (r_state == ST_OUT);
  assign gx_o        = r_gx;
  assign gy_o        = r_gy;
  assign mag_o       = r_mag;
`ifdef SOBEL_THRESH_EN
  assign edge_o      = r_edge;
`endif

  // Control FSM: accept window, two 6-tap passes, capture, hold result.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_tap   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (win_valid_i) begin
            r_tap   <= '0;
            r_state <= ST_GX;
          end
        end
        ST_GX: begin
          if (w_last_tap) begin
            r_tap   <= '0;
            r_state <= ST_GY;
          end else begin
            r_tap <= r_tap + 3'd1;
          end
        end
        ST_GY: begin
          if (w_last_tap) begin
            r_tap   <= '0;
            r_state <= ST_CAP;
          end else begin
            r_tap <= r_tap + 3'd1;
          end
        end
        ST_CAP: begin
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          if (res_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tap   <= '0;
        end
      endcase
    end
  end

  // Window latch at acceptance so later changes on win_i have no effect.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_win <= '0;
    end else if ((r_state == ST_IDLE) && win_valid_i) begin
      r_win <= win_i;
    end
  end

  // Result registers: Gx is read on GY tap 0 (O still holds Gx), Gy in CAP.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_gx  <= '0;
      r_gy  <= '0;
      r_mag <= '0;
`ifdef SOBEL_THRESH_EN
      r_edge <= 1'b0;
`endif
    end else begin
      if ((r_state == ST_GY) && (r_tap == 3'd0)) begin
        r_gx <= mac_o_i[10:0];
      end
      if (r_state == ST_CAP) begin
        r_gy  <= w_gy_cap;
        r_mag <= w_mag_sat;
`ifdef SOBEL_THRESH_EN
        r_edge <= (w_mag_sat > thresh_i);
`endif
      end
    end
  end

endmodule
